// File: rtl/lock_pkg.sv
// lock_pkg: shared state encoding and key decode helper for the keypad lock.
package lock_pkg;
    typedef enum logic [1:0] {ENTRY, OPEN, SET, ALARM} state_e;
    function automatic logic [4:0] onehot_to_bcd(input logic [9:0] b);
        logic [4:0] r;
        r = '0;
        for (int k = 0; k < 10; k++)
            if (b == (10'd1 << k)) r = {1'b1, 4'(k)};
        return r;
    endfunction
endpackage

// File: rtl/key_decode.sv
// key_decode: validates one-hot digit pulses and applies hash > star > digit priority.
module key_decode
    import lock_pkg::*;
(
    input  logic [9:0] button_i,
    input  logic       star_i,
    input  logic       hash_i,
    output logic       digit_vld_o,
    output logic [3:0] digit_o,
    output logic       star_vld_o,
    output logic       hash_vld_o
);
    logic [4:0] bcd;
    assign bcd         = onehot_to_bcd(button_i);
    assign hash_vld_o  = hash_i;
    assign star_vld_o  = star_i & ~hash_i;
    assign digit_vld_o = bcd[4] & ~star_i & ~hash_i;
    assign digit_o     = bcd[3:0];
endmodule

// File: rtl/keypad_lock_ctrl.sv
// keypad_lock_ctrl: PIN entry, compare, unlock timing, PIN change and failed-attempt lockout.
module keypad_lock_ctrl
    import lock_pkg::*;
#(
    parameter int                  DIGITS      = 4,
    parameter logic [4*DIGITS-1:0] DEFAULT_PIN = 16'h1234,
    parameter int                  OPEN_CYCLES = 8,
    parameter int                  LOCK_CYCLES = 16,
    parameter int                  MAX_FAIL    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] i_button,
    input  logic       i_star,
    input  logic       i_hash,
    output logic       o_open,
    output logic       o_alarm,
    output logic       o_set,
    output logic       o_fail,
    output logic       o_saved,
    output logic [3:0] o_cnt
);
    localparam int BW   = 4 * DIGITS;
    localparam int TMAX = OPEN_CYCLES > LOCK_CYCLES ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(MAX_FAIL + 1);

    state_e        state_q, state_d;
    logic [BW-1:0] buf_q, buf_d, pin_q, pin_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [FW-1:0] nfail_q, nfail_d;
    logic          fail_q, fail_d, saved_q, saved_d;
    logic          digit_vld, star_vld, hash_vld, full;
    logic [3:0]    digit;

    key_decode u_dec (
        .button_i    (i_button),
        .star_i      (i_star),
        .hash_i      (i_hash),
        .digit_vld_o (digit_vld),
        .digit_o     (digit),
        .star_vld_o  (star_vld),
        .hash_vld_o  (hash_vld)
    );

    assign full = cnt_q == 4'(DIGITS);

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        pin_d   = pin_q;
        timer_d = timer_q;
        nfail_d = nfail_q;
        fail_d  = 1'b0;
        saved_d = 1'b0;
        case (state_q)
            ENTRY, SET: begin
                if (hash_vld) begin
                    buf_d = '0;
                    cnt_d = '0;
                    if (state_q == SET) begin
                        state_d = ENTRY;
                        pin_d   = full ? buf_q : pin_q;
                        saved_d = full;
                        fail_d  = !full;
                    end else if (full && buf_q == pin_q) begin
                        state_d = OPEN;
                        timer_d = TW'(OPEN_CYCLES - 1);
                        nfail_d = '0;
                    end else begin
                        fail_d  = 1'b1;
                        nfail_d = nfail_q + FW'(1);
                        if (nfail_d == FW'(MAX_FAIL)) begin
                            state_d = ALARM;
                            timer_d = TW'(LOCK_CYCLES - 1);
                        end
                    end
                end else if (star_vld) begin
                    buf_d = '0;
                    cnt_d = '0;
                end else if (digit_vld && !full) begin
                    buf_d = (buf_q << 4) | BW'(digit);
                    cnt_d = cnt_q + 4'd1;
                end
            end
            OPEN: begin
                // Star abandons the unlock window and starts a PIN change
                if (hash_vld) begin
                    state_d = ENTRY;
                end else if (star_vld) begin
                    state_d = SET;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else if (timer_q == '0) begin
                    state_d = ENTRY;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                if (timer_q == '0) begin
                    state_d = ENTRY;
                    nfail_d = '0;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENTRY;
            buf_q   <= '0;
            cnt_q   <= '0;
            pin_q   <= DEFAULT_PIN;
            timer_q <= '0;
            nfail_q <= '0;
            fail_q  <= 1'b0;
            saved_q <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            pin_q   <= pin_d;
            timer_q <= timer_d;
            nfail_q <= nfail_d;
            fail_q  <= fail_d;
            saved_q <= saved_d;
        end
    end

    assign o_open  = state_q == OPEN;
    assign o_alarm = state_q == ALARM;
    assign o_set   = state_q == SET;
    assign o_fail  = fail_q;
    assign o_saved = saved_q;
    assign o_cnt   = cnt_q;
endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// tb_keypad_lock_ctrl: directed and random key sequences checked against a queue-based lock model.
module tb_keypad_lock_ctrl;
    localparam int DIGITS = 4;
    localparam int OPEN_C = 8;
    localparam int LOCK_C = 16;
    localparam int MAXF   = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] i_button;
    logic       i_star, i_hash;
    logic       o_open, o_alarm, o_set, o_fail, o_saved;
    logic [3:0] o_cnt;

    int checks = 0;
    int failures = 0;

    int entered[$];
    int pin_m[DIGITS];
    int open_left, alarm_left, fails;
    bit in_set, fail_e, saved_e;

    keypad_lock_ctrl #(
        .DIGITS(DIGITS), .DEFAULT_PIN(16'h1234), .OPEN_CYCLES(OPEN_C),
        .LOCK_CYCLES(LOCK_C), .MAX_FAIL(MAXF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_button(i_button), .i_star(i_star), .i_hash(i_hash),
        .o_open(o_open), .o_alarm(o_alarm), .o_set(o_set), .o_fail(o_fail),
        .o_saved(o_saved), .o_cnt(o_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        logic [15:0] dp;
        dp = 16'h1234;
        for (int k = 0; k < DIGITS; k++) pin_m[k] = int'(dp[4*(DIGITS-1-k) +: 4]);
        entered.delete();
        open_left = 0; alarm_left = 0; fails = 0;
        in_set = 0; fail_e = 0; saved_e = 0;
    endtask

    function automatic bit pin_matches();
        if (entered.size() != DIGITS) return 0;
        for (int k = 0; k < DIGITS; k++) if (entered[k] != pin_m[k]) return 0;
        return 1;
    endfunction

    task automatic model_step(input logic [9:0] b, input logic s, input logic h);
        int digit;
        digit = -1;
        if ($countones(b) == 1)
            for (int k = 0; k < 10; k++) if (b[k]) digit = k;
        fail_e = 0;
        saved_e = 0;
        if (alarm_left > 0) begin
            alarm_left--;
            if (alarm_left == 0) begin fails = 0; entered.delete(); end
        end else if (open_left > 0) begin
            if (h) open_left = 0;
            else if (s) begin open_left = 0; in_set = 1; entered.delete(); end
            else open_left--;
        end else if (h) begin
            if (in_set) begin
                if (entered.size() == DIGITS) begin
                    for (int k = 0; k < DIGITS; k++) pin_m[k] = entered[k];
                    saved_e = 1;
                end else fail_e = 1;
                in_set = 0;
            end else if (pin_matches()) begin
                open_left = OPEN_C;
                fails = 0;
            end else begin
                fail_e = 1;
                fails++;
                if (fails == MAXF) alarm_left = LOCK_C;
            end
            entered.delete();
        end else if (s) entered.delete();
        else if (digit >= 0 && entered.size() < DIGITS) entered.push_back(digit);
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".open"},  32'(o_open),  32'(open_left > 0));
        chk({ctx, ".alarm"}, 32'(o_alarm), 32'(alarm_left > 0));
        chk({ctx, ".set"},   32'(o_set),   32'(in_set));
        chk({ctx, ".fail"},  32'(o_fail),  32'(fail_e));
        chk({ctx, ".saved"}, 32'(o_saved), 32'(saved_e));
        chk({ctx, ".cnt"},   32'(o_cnt),   32'(entered.size()));
    endtask

    task automatic tick(input logic [9:0] b, input logic s, input logic h);
        @(negedge clk);
        i_button = b; i_star = s; i_hash = h;
        @(posedge clk);
        #1;
        i_button = '0; i_star = 1'b0; i_hash = 1'b0;
        model_step(b, s, h);
        check_all("step");
    endtask

    task automatic key(input int d);   tick(10'd1 << d, 1'b0, 1'b0); endtask
    task automatic hash();              tick('0, 1'b0, 1'b1);         endtask
    task automatic star();              tick('0, 1'b1, 1'b0);         endtask
    task automatic idle(input int n);   repeat (n) tick('0, 1'b0, 1'b0); endtask
    task automatic pin4(input int a, input int b, input int c, input int d);
        key(a); key(b); key(c); key(d);
    endtask

    // Reset lands between clock edges; outputs must clear without waiting for a clock
    task automatic reset_mid();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        logic [9:0] mb;
        rst_n = 1'b0; i_button = '0; i_star = 1'b0; i_hash = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        pin4(1, 2, 3, 4); hash(); idle(9);

        repeat (3) begin pin4(1, 2, 3, 5); hash(); end
        pin4(1, 2, 3, 4); hash();
        idle(12);
        pin4(1, 2, 3, 4); hash(); idle(9);

        pin4(1, 2, 3, 4); key(5); hash(); idle(9);
        key(1); key(2); star(); pin4(1, 2, 3, 4); hash(); idle(9);
        key(1); key(2); key(3); hash();

        pin4(1, 2, 3, 4); tick(10'b0000000011, 1'b0, 1'b0); tick('0, 1'b1, 1'b1); idle(9);
        key(1); key(2); tick(10'b0000000100, 1'b1, 1'b1);

        pin4(1, 2, 3, 4); hash(); star(); pin4(9, 8, 7, 6); hash();
        pin4(1, 2, 3, 4); hash();
        pin4(9, 8, 7, 6); hash(); idle(9);

        pin4(9, 8, 7, 6); hash(); idle(2);
        reset_mid();
        pin4(1, 2, 3, 4); hash(); star(); key(5); key(6);
        reset_mid();
        pin4(1, 2, 3, 4); hash(); star(); pin4(9, 8, 7, 6); hash(); key(3);
        reset_mid();
        pin4(1, 2, 3, 4); hash(); idle(9);

        repeat (500) begin
            r = int'($urandom_range(0, 31));
            if (r < 10) key(r);
            else if (r < 12) star();
            else if (r < 14) hash();
            else if (r == 14) begin
                mb = 10'($urandom);
                if ($countones(mb) < 2) mb = 10'b0110000000;
                tick(mb, 1'b0, 1'b0);
            end else if (r == 15) tick(10'd1 << $urandom_range(0, 9), 1'($urandom), 1'b1);
            else if (r < 18) begin
                for (int k = 0; k < DIGITS; k++) key(pin_m[k]);
                hash();
            end else if (r == 18) begin
                star();
                for (int k = 0; k < DIGITS; k++) key(int'($urandom_range(0, 9)));
            end else idle(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
